// File: rtl/if_id_stage.sv
// Instruction fetch stage with the IF/ID pipeline register.
// Owns the PC, drives the req/ready instruction port and decodes fields.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall_ID,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ready,
  input  logic [31:0] IMem_Data,
  output logic [31:0] Instr_ID,
  output logic [31:0] PC_Plus4_ID,
  output logic        Valid_ID,
  output logic [5:0]  Opcode_ID,
  output logic [4:0]  Rs_ID,
  output logic [4:0]  Rt_ID,
  output logic [4:0]  Rd_ID,
  output logic [5:0]  Shamt_ID,
  output logic [5:0]  Funct_ID
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HELD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] tgt_q, tgt_d;

  logic        xfer;
  logic [31:0] pc_inc;
  logic [31:0] br_tgt;

  assign IMem_Req  = Rst & (state_q != HELD);
  assign IMem_Addr = pc_q;
  assign xfer      = IMem_Req & IMem_Ready;
  assign pc_inc    = pc_q + 32'd4;
  assign br_tgt    = {Branch_Target[31:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    tgt_d        = tgt_q;
    unique case (state_q)
      FETCH: begin
        if (Branch_Taken) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (xfer) begin
            pc_d = br_tgt;
          end else begin
            tgt_d   = br_tgt;
            state_d = DRAIN;
          end
        end else if (xfer) begin
          pc_d = pc_inc;
          if (Stall_ID) begin
            skid_instr_d = IMem_Data;
            skid_pc4_d   = pc_inc;
            state_d      = HELD;
          end else begin
            instr_d = IMem_Data;
            pc4_d   = pc_inc;
            valid_d = 1'b1;
          end
        end else if (!Stall_ID) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      HELD: begin
        if (Branch_Taken) begin
          pc_d    = br_tgt;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = FETCH;
        end else if (!Stall_ID) begin
          instr_d = skid_instr_q;
          pc4_d   = skid_pc4_q;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // the outstanding request must complete before we can redirect
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        if (Branch_Taken) tgt_d = br_tgt;
        if (xfer) begin
          pc_d    = Branch_Taken ? br_tgt : tgt_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc4_q        <= 32'd0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      tgt_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      tgt_q        <= tgt_d;
    end
  end

  assign Instr_ID    = instr_q;
  assign PC_Plus4_ID = pc4_q;
  assign Valid_ID    = valid_q;
  assign Opcode_ID   = instr_q[31:26];
  assign Rs_ID       = instr_q[25:21];
  assign Rt_ID       = instr_q[20:16];
  assign Rd_ID       = instr_q[15:11];
  assign Shamt_ID    = {1'b0, instr_q[10:6]};
  assign Funct_ID    = instr_q[5:0];

endmodule
